keygen: RTL and testbench

KEYGEN -- requirements
Module: keygen

---
 rtl/keygen.sv | 120 ++++++++++++
 tb/tb_keygen.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/keygen.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : keygen
// Purpose  : One round of the AES-128 key schedule, with a registered output.
//            When key_gen_enable is high, key_out is loaded with the expansion
//            of prev_key for round iteration_num. When it is low, key_out is
//            loaded with key_in unchanged. A single 128-bit register is the
//            only state in the block.
// Revision : 1.0  initial release
//
// Ports
//   clk            in   1    rising-edge clock
//   n_rst          in   1    asynchronous active-low reset (clears key_out)
//   key_gen_enable in   1    1 = expand prev_key, 0 = load key_in
//   key_in         in   128  round-0 cipher key
//   prev_key       in   128  round i-1 key to expand
//   iteration_num  in   4    round index i (1..10 select an rcon, others -> 00)
//   key_out        out  128  registered round key
//------------------------------------------------------------------------------
module keygen (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         key_gen_enable,
  input  logic [127:0] key_in,
  input  logic [127:0] prev_key,
  input  logic [3:0]   iteration_num,
  output logic [127:0] key_out
);

  // Forward AES S-box packed as one vector. Entry 0 is in the top byte, so
  // entry k sits at bits [2047-8k -: 8]. 2047-8k equals {~k, 3'b111}.
  localparam logic [2047:0] C_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return C_SBOX[{~b, 3'b111} -: 8];
  endfunction

  logic [127:0] key_out_q;
  logic [127:0] key_out_d;

  logic [31:0] w0;
  logic [31:0] w1;
  logic [31:0] w2;
  logic [31:0] w3;
  logic [31:0] rot_w;
  logic [31:0] sub_w;
  logic [31:0] temp_w;
  logic [31:0] n0;
  logic [31:0] n1;
  logic [31:0] n2;
  logic [31:0] n3;
  logic [7:0]  rcon;

  assign w0 = prev_key[127:96];
  assign w1 = prev_key[95:64];
  assign w2 = prev_key[63:32];
  assign w3 = prev_key[31:0];

  // RotWord: the top byte wraps around to the bottom.
  assign rot_w = {w3[23:0], w3[31:24]};

  assign sub_w = {sbox(rot_w[31:24]), sbox(rot_w[23:16]),
                  sbox(rot_w[15:8]),  sbox(rot_w[7:0])};

  // Round indices outside 1..10 get a zero rcon. The rest of the round is
  // still applied and no error is signalled.
  always_comb begin
    rcon = 8'h00;
    case (iteration_num)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign temp_w = sub_w ^ {rcon, 24'h000000};
  assign n0     = w0 ^ temp_w;
  assign n1     = w1 ^ n0;
  assign n2     = w2 ^ n1;
  assign n3     = w3 ^ n2;

  assign key_out_d = key_gen_enable ? {n0, n1, n2, n3} : key_in;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      key_out_q <= 128'h0;
    end else begin
      key_out_q <= key_out_d;
    end
  end

  assign key_out = key_out_q;

endmodule
`default_nettype wire

// File: tb/tb_keygen.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_keygen
// Purpose  : Self-checking bench for keygen. The reference model derives the
//            S-box from GF(2^8) inversion followed by the affine map. It
//            derives rcon by repeated doubling in the field.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module tb_keygen;

  logic         clk;
  logic         n_rst;
  logic         key_gen_enable;
  logic [127:0] key_in;
  logic [127:0] prev_key;
  logic [3:0]   iteration_num;
  logic [127:0] key_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] sb [256];

  keygen dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .key_gen_enable (key_gen_enable),
    .key_in         (key_in),
    .prev_key       (prev_key),
    .iteration_num  (iteration_num),
    .key_out        (key_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254. Zero maps to zero.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    for (int k = 0; k < 254; k++) r = gmul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  function automatic logic [7:0] sbox_m(input logic [7:0] x);
    logic [7:0] b = ginv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon_m(input int it);
    logic [7:0] r = 8'h01;
    if (it < 1 || it > 10) return 8'h00;
    for (int k = 1; k < it; k++) r = xtime(r);
    return r;
  endfunction

  function automatic logic [127:0] expand_m(input logic [127:0] pk, input int it);
    logic [31:0] w [4];
    logic [7:0]  b [4];
    logic [31:0] t;
    logic [31:0] n [4];
    for (int k = 0; k < 4; k++) w[k] = pk[127 - 32*k -: 32];
    for (int k = 0; k < 4; k++) b[k] = w[3][31 - 8*k -: 8];
    t = {sb[b[1]] ^ rcon_m(it), sb[b[2]], sb[b[3]], sb[b[0]]};
    n[0] = w[0] ^ t;
    for (int k = 1; k < 4; k++) n[k] = w[k] ^ n[k-1];
    return {n[0], n[1], n[2], n[3]};
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive inputs away from the active edge, then sample 1 time unit after it.
  task automatic step(input logic en, input logic [127:0] kin,
                      input logic [127:0] pk, input logic [3:0] it);
    @(negedge clk);
    key_gen_enable = en;
    key_in         = kin;
    prev_key       = pk;
    iteration_num  = it;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus ----------------
  initial begin : main
    logic [127:0] seed_key;
    logic [127:0] k;
    logic [127:0] e;
    logic [127:0] r1;
    logic         en;
    logic [3:0]   it;

    seed_key = 128'h30313233343536373839414243444546;
    for (int x = 0; x < 256; x++) sb[x] = sbox_m(x[7:0]);

    // Reset takes effect without a clock edge and holds across edges.
    n_rst = 1'b1; key_gen_enable = 1'b1; key_in = rnd128();
    prev_key = rnd128(); iteration_num = 4'd3;
    #2 n_rst = 1'b0;
    #1 check("reset_async", key_out, 128'h0);
    @(posedge clk); #1 check("reset_hold1", key_out, 128'h0);
    @(posedge clk); #1 check("reset_hold2", key_out, 128'h0);
    @(negedge clk); n_rst = 1'b1;

    // Pass-through path.
    step(1'b0, 128'h68656c6c6f3030303030303030303030, rnd128(), 4'd7);
    check("pass_hello", key_out, 128'h68656c6c6f3030303030303030303030);

    // Asynchronous reset with the clock high and the output nonzero.
    @(posedge clk); #2 n_rst = 1'b0;
    #1 check("reset_mid_high", key_out, 128'h0);
    @(negedge clk); n_rst = 1'b1;

    // Known expansion vectors.
    step(1'b1, rnd128(), 128'h68656c6c6f3030303030303030303030, 4'd1);
    check("iter1_hello", key_out, 128'h6d616868025158583261686802515858);
    step(1'b1, rnd128(), 128'h68656c6c6f3030303030303030303030, 4'd0);
    check("iter0_topbyte", {120'h0, key_out[127:120]}, 128'h6c);
    check("iter0_model", key_out, expand_m(128'h68656c6c6f3030303030303030303030, 0));
    step(1'b1, rnd128(), 128'h6ca93273598a3c2f038759c18746bb83, 4'd10);
    check("iter10_vec", key_out, 128'h0043de6459c9e24b5a4ebb8add080009);
    step(1'b1, rnd128(), 128'hc45f899e43390bb2eb94509096edd807, 4'd9);
    check("iter9_vec", key_out, 128'h8a3e4c0ec90747bc2293172cb47ecf2b);
    step(1'b1, rnd128(), 128'h68656c6c6f3030303030303030303030, 4'd15);
    check("iter15_model", key_out, expand_m(128'h68656c6c6f3030303030303030303030, 15));

    // Full ten-round chain. prev_key is fed from the model's previous key.
    step(1'b0, seed_key, rnd128(), 4'd0);
    check("chain_load", key_out, seed_key);
    k = seed_key;
    r1 = 128'h0;
    for (int i = 1; i <= 10; i++) begin
      e = expand_m(k, i);
      step(1'b1, rnd128(), k, i[3:0]);
      check($sformatf("chain_r%0d", i), key_out, e);
      if (i == 1) r1 = key_out;
      k = e;
    end
    check("chain_r1_const", r1, 128'h2a5f68291e6a5e1e26531f5c65175a1a);
    check("chain_r10_const", key_out, 128'h41dce20887d2dea92f284e8bbeeefb52);

    // Reset during round 5, then restart the chain from the reloaded key.
    step(1'b0, seed_key, rnd128(), 4'd0);
    k = seed_key;
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, rnd128(), k, i[3:0]);
      k = expand_m(k, i);
    end
    @(negedge clk);
    prev_key = k; iteration_num = 4'd5; key_gen_enable = 1'b1;
    #2 n_rst = 1'b0;
    #1 check("chain_reset_r5", key_out, 128'h0);
    @(posedge clk); #1 check("chain_reset_hold", key_out, 128'h0);
    @(negedge clk); n_rst = 1'b1;
    step(1'b0, seed_key, rnd128(), 4'd5);
    check("chain2_load", key_out, seed_key);
    k = seed_key;
    for (int i = 1; i <= 10; i++) begin
      e = expand_m(k, i);
      step(1'b1, rnd128(), k, i[3:0]);
      check($sformatf("chain2_r%0d", i), key_out, e);
      k = e;
    end
    check("chain2_r10_const", key_out, 128'h41dce20887d2dea92f284e8bbeeefb52);

    // Random cycles: enable and round index change freely between cycles.
    for (int i = 0; i < 60; i++) begin
      en = $urandom_range(0, 1);
      it = 4'($urandom_range(0, 15));
      key_in = rnd128();
      k = rnd128();
      e = en ? expand_m(k, int'(it)) : key_in;
      step(en, key_in, k, it);
      check($sformatf("rand%0d", i), key_out, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
